mips_trace_tx: RTL and testbench



---
 rtl/mips_trace_tx_pkg.sv | 16 +
 rtl/mips_trace_tx_if.sv | 38 +++
 rtl/mips_trace_tx_fifo.sv | 51 +++++
 rtl/mips_trace_tx.sv | 125 ++++++++++++
 tb/tb_mips_trace_tx.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/mips_trace_tx_pkg.sv
// Shared types and constants for the MIPS-16 trace serializer.
// Frame = start bit followed by {pc, alu} MSB first.
package mips_trace_pkg;

  localparam int TRACE_W = 32;
  localparam int PC_W    = 16;

  localparam logic START_BIT = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    SHIFT
  } tx_state_e;

endpackage

// File: rtl/mips_trace_tx_if.sv
// Core-side trace inputs and pad-side serial link of the trace serializer.
// master drives the core/pad inputs, slave is the serializer.
interface mips_trace_tx_if #(
  parameter int DEPTH = 8
);

  logic [15:0]             pc_in;
  logic [15:0]             alu_in;
  logic                    trace_en;
  logic                    tx_ready;
  logic                    tx_sd;
  logic                    tx_valid;
  logic [$clog2(DEPTH):0]  fifo_level;
  logic                    overflow;

  modport master (
    output pc_in,
    output alu_in,
    output trace_en,
    output tx_ready,
    input  tx_sd,
    input  tx_valid,
    input  fifo_level,
    input  overflow
  );

  modport slave (
    input  pc_in,
    input  alu_in,
    input  trace_en,
    input  tx_ready,
    output tx_sd,
    output tx_valid,
    output fifo_level,
    output overflow
  );

endinterface

// File: rtl/mips_trace_tx_fifo.sv
// Single-clock trace word FIFO; a push on full succeeds
// only when a pop frees a slot in the same cycle.
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_dout  = r_mem[r_rd];

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

endmodule

// File: rtl/mips_trace_tx.sv
// Captures {pc, alu} on every PC change and streams buffered
// words over a start-bit framed serial link.
module mips_trace_tx
  import mips_trace_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  mips_trace_tx_if.slave   bus
);

  logic [PC_W-1:0]    r_pc_prev;
  logic               r_prev_valid;
  logic               r_ovf;
  tx_state_e          r_state;
  tx_state_e          w_state_nx;
  logic [TRACE_W-1:0] r_shift;
  logic [TRACE_W-1:0] w_shift_nx;
  logic [4:0]         r_cnt;
  logic [4:0]         w_cnt_nx;
  logic               r_sd;
  logic               w_sd_nx;
  logic               r_valid;
  logic               w_valid_nx;

  logic               w_cap;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [TRACE_W-1:0] w_dout;
  logic [LW-1:0]      w_level;

  assign w_cap = bus.trace_en &&
                 (!r_prev_valid || bus.pc_in != r_pc_prev);

  trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TRACE_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_cap),
    .i_din   ({bus.pc_in, bus.alu_in}),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_prev    <= '0;
      r_prev_valid <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_pc_prev    <= bus.pc_in;
      r_prev_valid <= 1'b1;
      if (w_cap && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  // Outputs are registered from the next state, so pads mirror r_state.
  always_comb begin
    w_state_nx = r_state;
    w_shift_nx = r_shift;
    w_cnt_nx   = r_cnt;
    w_sd_nx    = 1'b0;
    w_valid_nx = 1'b0;
    w_pop      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty && bus.tx_ready) begin
          w_pop      = 1'b1;
          w_state_nx = START;
          w_shift_nx = w_dout;
          w_valid_nx = 1'b1;
          w_sd_nx    = START_BIT;
        end
      end
      START: begin
        w_state_nx = SHIFT;
        w_cnt_nx   = 5'd31;
        w_valid_nx = 1'b1;
        w_sd_nx    = r_shift[TRACE_W-1];
        w_shift_nx = r_shift << 1;
      end
      SHIFT: begin
        if (r_cnt == 5'd0) begin
          w_state_nx = IDLE;
        end else begin
          w_cnt_nx   = r_cnt - 5'd1;
          w_valid_nx = 1'b1;
          w_sd_nx    = r_shift[TRACE_W-1];
          w_shift_nx = r_shift << 1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_sd    <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_shift <= w_shift_nx;
      r_cnt   <= w_cnt_nx;
      r_sd    <= w_sd_nx;
      r_valid <= w_valid_nx;
    end
  end

  assign bus.tx_sd      = r_sd;
  assign bus.tx_valid   = r_valid;
  assign bus.fifo_level = w_level;
  assign bus.overflow   = r_ovf;

endmodule

// File: tb/tb_mips_trace_tx.sv
// Bench for mips_trace_tx: directed scenarios plus random traffic
// checked every cycle against a queue-based frame model.
module tb_mips_trace_tx;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mips_trace_tx_if #(.DEPTH(8)) bus ();

  mips_trace_tx #(.FIFO_DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q[$];
  bit          pend[$];
  bit          m_pv  = 1'b0;
  logic [15:0] m_pc  = 16'h0;
  bit          m_ovf = 1'b0;
  bit          m_v   = 1'b0;
  bit          m_sd  = 1'b0;
  int          cyc   = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic step(bit rst, bit en, bit rdy,
                      logic [15:0] pc, logic [15:0] alu);
    bit          pop;
    logic [31:0] w;
    @(negedge clk);
    reset        = rst;
    bus.trace_en = en;
    bus.tx_ready = rdy;
    bus.pc_in    = pc;
    bus.alu_in   = alu;
    if (rst) begin
      q.delete();
      pend.delete();
      m_pv  = 1'b0;
      m_ovf = 1'b0;
      m_v   = 1'b0;
      m_sd  = 1'b0;
    end else begin
      pop = !m_v && q.size() > 0 && rdy;
      if (pop) begin
        w = q.pop_front();
        pend.push_back(1'b1);
        for (int i = 31; i >= 0; i--) pend.push_back(w[i]);
      end
      if (en && (!m_pv || pc != m_pc)) begin
        if (q.size() < 8) q.push_back({pc, alu});
        else m_ovf = 1'b1;
      end
      m_pv = 1'b1;
      m_pc = pc;
      if (pend.size() > 0) begin
        m_v  = 1'b1;
        m_sd = pend.pop_front();
      end else begin
        m_v  = 1'b0;
        m_sd = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("tx_sd", 32'(bus.tx_sd), 32'(m_sd));
    chk("tx_valid", 32'(bus.tx_valid), 32'(m_v));
    chk("level", 32'(bus.fifo_level), 32'(q.size()));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
  endtask

  initial begin
    int          nv;
    int          nrise;
    bit          pv;
    logic [31:0] word;
    int          nb;
    int          last;
    logic [15:0] rpc;

    // reset with random inputs
    for (int i = 0; i < 3; i++)
      step(1, 1'($urandom), 1'($urandom),
           16'($urandom), 16'($urandom));
    chk("rst_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_level", 32'(bus.fifo_level), 32'd0);

    // single frame
    step(0, 0, 1, 16'h0000, 16'h0);
    step(0, 0, 1, 16'h0000, 16'h0);
    nv = 0; word = '0; nb = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 1, 16'h0002, 16'h1234);
      if (bus.tx_valid) begin
        if (nb == 0) chk("sf_start", 32'(bus.tx_sd), 32'd1);
        else word = {word[30:0], bus.tx_sd};
        nb++;
        nv++;
      end
      if (i == 1) chk("sf_lat", 32'(bus.tx_valid), 32'd1);
    end
    chk("sf_vcnt", 32'(nv), 32'd33);
    chk("sf_word", word, 32'h00021234);

    // PC stall
    nrise = 0; pv = 0;
    for (int i = 0; i < 46; i++) begin
      step(0, 1, 1, 16'h0010, 16'($urandom));
      if (bus.tx_valid && !pv) nrise++;
      pv = bus.tx_valid;
    end
    chk("stall_frames", 32'(nrise), 32'd1);

    // overflow then drain
    for (int i = 0; i < 9; i++)
      step(0, 1, 0, 16'h0100 + 16'(i), 16'($urandom));
    step(0, 1, 0, 16'h0108, 16'h0);
    chk("ov_level", 32'(bus.fifo_level), 32'd8);
    chk("ov_flag", 32'(bus.overflow), 32'd1);
    nrise = 0; pv = 0; last = 0;
    for (int i = 0; i < 8 * 34 + 10; i++) begin
      step(0, 1, 1, 16'h0108, 16'h0);
      if (bus.tx_valid && !pv) begin
        if (nrise > 0) chk("ov_period", 32'(i - last), 32'd34);
        last = i;
        nrise++;
      end
      pv = bus.tx_valid;
    end
    chk("ov_frames", 32'(nrise), 32'd8);
    chk("ov_sticky", 32'(bus.overflow), 32'd1);

    // push on full with simultaneous pop
    step(1, 0, 0, 16'h01FF, 16'h0);
    step(0, 0, 0, 16'h01FF, 16'h0);
    for (int i = 0; i < 8; i++)
      step(0, 1, 0, 16'h0200 + 16'(i), 16'($urandom));
    step(0, 1, 0, 16'h0207, 16'h0);
    step(0, 1, 1, 16'h0208, 16'hBEEF);
    chk("pf_level", 32'(bus.fifo_level), 32'd8);
    chk("pf_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 9 * 34 + 5; i++)
      step(0, 1, 1, 16'h0208, 16'h0);
    chk("pf_drained", 32'(bus.fifo_level), 32'd0);

    // reset mid-frame at data bit 10
    step(0, 1, 1, 16'h0300, 16'h5A5A);
    for (int i = 0; i < 12; i++)
      step(0, 1, 1, 16'h0300, 16'h5A5A);
    chk("mf_busy", 32'(bus.tx_valid), 32'd1);
    step(1, 1, 1, 16'h0300, 16'h5A5A);
    chk("mf_valid", 32'(bus.tx_valid), 32'd0);
    chk("mf_level", 32'(bus.fifo_level), 32'd0);
    step(0, 0, 1, 16'h0300, 16'h0);
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 1, 16'h0301, 16'hC3C3);
      if (bus.tx_valid) nv++;
    end
    chk("mf_vcnt", 32'(nv), 32'd33);

    // random traffic
    rpc = 16'h0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) rpc = 16'($urandom_range(0, 7) * 2);
      step(($urandom_range(0, 599) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0),
           rpc, 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
